ci_test_monitor: RTL and testbench
==================================

CI_TEST_MONITOR -- requirements
Module: ci_test_monitor

Interface
REQ-001 Parameter N_TESTS, default 4, number of test lanes monitored (1..32).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, RUN cycles allowed before timeout (>=2).
REQ-003 Parameter IDX_W, default 5, width of first_fail_idx.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fail  input  N_TESTS  per-lane fail flag, one per test instance, level or pulse.
REQ-007 finish  input  N_TESTS  per-lane finish flag, one per test instance, level or pulse.
REQ-008 done  output  1  high in any terminal state.
REQ-009 pass  output  1  high only in state PASS.
REQ-010 timeout  output  1  high only in state TIMEOUT.
REQ-011 fail_mask  output  N_TESTS  sticky per-lane record of fail seen.
REQ-012 first_fail_idx  output  IDX_W  index of the first lane to report fail.
REQ-013 cycles  output  32  RUN-cycle count.

Function
REQ-014 The block SHALL implement the states RUN, PASS, FAIL and TIMEOUT; it SHALL enter RUN on reset, and PASS, FAIL and TIMEOUT SHALL be terminal until reset.
REQ-015 In RUN, the block SHALL update fin_seen <= fin_seen | finish and fail_mask <= fail_mask | fail every cycle.
REQ-016 In RUN, when (fin_seen | finish) is all-ones, the next state SHALL be FAIL if (fail_mask | fail) != 0, otherwise PASS, with latency 1 cycle from the last finish edge.
REQ-017 A fail on a lane that has already finished SHALL still be recorded while in RUN.
REQ-018 Fail or finish inputs arriving in a terminal state SHALL be ignored, and fail_mask SHALL be frozen.
REQ-019 first_fail_idx SHALL latch on the first cycle in which fail_mask is zero and fail != 0.
REQ-020 When several fail bits rise in that same cycle, first_fail_idx SHALL take the lowest index; later fails SHALL NOT change it.
REQ-021 cycles SHALL increment by 1 on each RUN cycle, saturate at 0xFFFFFFFF, and hold its value in terminal states.
REQ-022 The outputs SHALL be decoded from the registered state as follows: done = state != RUN; pass = state == PASS; timeout = state == TIMEOUT.

Reset
REQ-023 While reset is high, the block SHALL set state to RUN and clear fin_seen, fail_mask, first_fail_idx and cycles, so that done, pass and timeout are 0.
REQ-024 Reset asserted mid-RUN or in a terminal state SHALL take effect on the next edge, and the block SHALL discard all prior history.
REQ-025 Inputs present during a reset cycle SHALL NOT be recorded.

Configuration
REQ-026 Macro CI_TEST_MONITOR_TIMEOUT_EN SHALL control the timeout feature.
REQ-027 With CI_TEST_MONITOR_TIMEOUT_EN defined, RUN SHALL go to TIMEOUT when cycles == TIMEOUT_CYCLES-1 and the all-finished condition of REQ-016 is false.
REQ-028 With CI_TEST_MONITOR_TIMEOUT_EN defined, completion of all lanes in the same cycle as the timeout condition SHALL take priority and yield PASS or FAIL.
REQ-029 Without CI_TEST_MONITOR_TIMEOUT_EN, the TIMEOUT state and its comparator SHALL be absent, timeout SHALL be tied to 0, and RUN SHALL persist indefinitely.

Verification (N_TESTS=4, TIMEOUT_CYCLES=16, macro defined unless noted)
REQ-030 Stimulus: reset 2 cycles, then finish=4'b1111, fail=0 on cycle 3 -> required response: one cycle later pass=1, done=1, fail_mask=0, cycles=3.
REQ-031 Stimulus: finish bits pulsed one lane at a time on cycles 1,4,6,9, with fail[2] pulsed on cycle 2 and fail[1] pulsed on cycle 7 -> required response: FAIL after cycle 9, fail_mask=4'b0110, first_fail_idx=2.
REQ-032 Stimulus: fail=4'b1010 in a single cycle, then all lanes finish -> required response: first_fail_idx=1, pass=0.
REQ-033 Stimulus: finish=4'b0111 held and lane 3 never finishes -> required response: timeout=1 after 16 RUN cycles, cycles=15; with the macro undefined, done stays 0 for 100 cycles.
REQ-034 Stimulus: lane 3 finishes exactly on cycle 15 -> required response: PASS, not TIMEOUT.
REQ-035 Stimulus: reset asserted mid-RUN after fail[0] -> required response: fail_mask=0, cycles=0, and a clean subsequent run reports pass=1.

Source files
------------

// File: rtl/ci_test_monitor_if.sv
// rtl/ci_test_monitor_if.sv - lane flags and verdict outputs of the CI test monitor
interface ci_test_monitor_if #(
    parameter int N_TESTS = 4,
    parameter int IDX_W   = 5
);
    logic [N_TESTS-1:0] fail;
    logic [N_TESTS-1:0] finish;
    logic               done;
    logic               pass;
    logic               timeout;
    logic [N_TESTS-1:0] fail_mask;
    logic [IDX_W-1:0]   first_fail_idx;
    logic [31:0]        cycles;

    // Test harness side: drives lane flags, observes the verdict
    modport master (
        output fail, finish,
        input  done, pass, timeout, fail_mask, first_fail_idx, cycles
    );

    // Monitor side
    modport slave (
        input  fail, finish,
        output done, pass, timeout, fail_mask, first_fail_idx, cycles
    );
endinterface

// File: rtl/ci_test_monitor.sv
// rtl/ci_test_monitor.sv - aggregates per-lane fail/finish into a run verdict (timeout under CI_TEST_MONITOR_TIMEOUT_EN)
module ci_test_monitor #(
    parameter int N_TESTS        = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int IDX_W          = 5
) (
    input  logic              clock,
    input  logic              reset,
    ci_test_monitor_if.slave  mon_if
);

`ifdef CI_TEST_MONITOR_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;
`endif

    state_t             state_q;
    logic [N_TESTS-1:0] fin_seen_q;
    logic [N_TESTS-1:0] fail_mask_q;
    logic [IDX_W-1:0]   first_idx_q;
    logic [31:0]        cycles_q;
    logic               done_q;
    logic               pass_q;

    logic [N_TESTS-1:0] fin_seen_d;
    logic [N_TESTS-1:0] fail_mask_d;
    logic [IDX_W-1:0]   first_idx_d;
    logic               all_fin;

    // Include this cycle's flags so completion is decided with one cycle of latency
    assign fin_seen_d  = fin_seen_q | mon_if.finish;
    assign fail_mask_d = fail_mask_q | mon_if.fail;
    assign all_fin     = &fin_seen_d;

    // Lowest-numbered lane raising fail this cycle
    always_comb begin
        first_idx_d = '0;
        for (int i = N_TESTS - 1; i >= 0; i--) begin
            if (mon_if.fail[i]) begin
                first_idx_d = IDX_W'(i);
            end
        end
    end

`ifdef CI_TEST_MONITOR_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic timeout_q;
    logic to_hit;

    assign to_hit         = (cycles_q == TO_LAST);
    assign mon_if.timeout = timeout_q;
`else
    // Timeout hardware is structurally absent in this build
    wire [31:0] unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign mon_if.timeout = 1'b0;
`endif

    // Run-state FSM: records lane history while running, freezes everything once a verdict is reached.
    // cycles counts RUN cycles that stayed in RUN, so it ends up holding the index of the deciding cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            fin_seen_q  <= '0;
            fail_mask_q <= '0;
            first_idx_q <= '0;
            cycles_q    <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
`ifdef CI_TEST_MONITOR_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    fin_seen_q  <= fin_seen_d;
                    fail_mask_q <= fail_mask_d;
                    if (fail_mask_q == '0 && mon_if.fail != '0) begin
                        first_idx_q <= first_idx_d;
                    end
                    if (all_fin) begin
                        done_q <= 1'b1;
                        if (fail_mask_d != '0) begin
                            state_q <= ST_FAIL;
                        end else begin
                            state_q <= ST_PASS;
                            pass_q  <= 1'b1;
                        end
                    end
`ifdef CI_TEST_MONITOR_TIMEOUT_EN
                    else if (to_hit) begin
                        state_q   <= ST_TIMEOUT;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
`endif
                    else if (cycles_q != 32'hFFFF_FFFF) begin
                        cycles_q <= cycles_q + 32'd1;
                    end
                end
                default: begin
                    // Terminal: inputs ignored, all history held until reset
                end
            endcase
        end
    end

    assign mon_if.done           = done_q;
    assign mon_if.pass           = pass_q;
    assign mon_if.fail_mask      = fail_mask_q;
    assign mon_if.first_fail_idx = first_idx_q;
    assign mon_if.cycles         = cycles_q;

endmodule

// File: tb/tb_ci_test_monitor.sv
// tb/tb_ci_test_monitor.sv - directed self-checking bench for ci_test_monitor
module tb_ci_test_monitor;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clock = ~clock;

    ci_test_monitor_if #(.N_TESTS(4), .IDX_W(5)) mon_if ();

    ci_test_monitor #(
        .N_TESTS        (4),
        .TIMEOUT_CYCLES (16),
        .IDX_W          (5)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .mon_if (mon_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mon_if.fail   = '0;
        mon_if.finish = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic stuck_done;

        // Reset state
        do_reset();
        check("rst_done",  32'(mon_if.done), 32'd0);
        check("rst_pass",  32'(mon_if.pass), 32'd0);
        check("rst_tmo",   32'(mon_if.timeout), 32'd0);
        check("rst_mask",  32'(mon_if.fail_mask), 32'd0);
        check("rst_idx",   32'(mon_if.first_fail_idx), 32'd0);
        check("rst_cyc",   mon_if.cycles, 32'd0);

        // All lanes finish together on cycle 3, no fails
        step(); step(); step();
        mon_if.finish = 4'b1111;
        step();
        mon_if.finish = '0;
        check("all_pass",  32'(mon_if.pass), 32'd1);
        check("all_done",  32'(mon_if.done), 32'd1);
        check("all_mask",  32'(mon_if.fail_mask), 32'd0);
        check("all_cyc",   mon_if.cycles, 32'd3);

        // Staggered finishes with two fail pulses
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            mon_if.fail   = '0;
            mon_if.finish = '0;
            case (c)
                1: mon_if.finish = 4'b0001;
                2: mon_if.fail   = 4'b0100;
                4: mon_if.finish = 4'b0010;
                6: mon_if.finish = 4'b0100;
                7: mon_if.fail   = 4'b0010;
                9: mon_if.finish = 4'b1000;
                default: ;
            endcase
            if (c == 9) check("stag_pre_done", 32'(mon_if.done), 32'd0);
            step();
        end
        mon_if.finish = '0;
        check("stag_done", 32'(mon_if.done), 32'd1);
        check("stag_pass", 32'(mon_if.pass), 32'd0);
        check("stag_mask", 32'(mon_if.fail_mask), 32'h6);
        check("stag_idx",  32'(mon_if.first_fail_idx), 32'd2);
        check("stag_cyc",  mon_if.cycles, 32'd9);

        // Simultaneous fails pick lowest lane; terminal state ignores later inputs
        do_reset();
        mon_if.fail = 4'b1010;
        step();
        mon_if.fail   = '0;
        mon_if.finish = 4'b1111;
        step();
        mon_if.finish = '0;
        check("sim_idx",  32'(mon_if.first_fail_idx), 32'd1);
        check("sim_pass", 32'(mon_if.pass), 32'd0);
        check("sim_done", 32'(mon_if.done), 32'd1);
        mon_if.fail = 4'b0001;
        step(); step();
        mon_if.fail = '0;
        check("frz_mask", 32'(mon_if.fail_mask), 32'hA);
        check("frz_idx",  32'(mon_if.first_fail_idx), 32'd1);
        check("frz_cyc",  mon_if.cycles, 32'd1);

        // Lane 3 never finishes
        do_reset();
        mon_if.finish = 4'b0111;
`ifdef CI_TEST_MONITOR_TIMEOUT_EN
        for (int c = 0; c < 15; c++) step();
        check("to_pre_done", 32'(mon_if.done), 32'd0);
        check("to_pre_cyc",  mon_if.cycles, 32'd15);
        step();
        check("to_tmo",  32'(mon_if.timeout), 32'd1);
        check("to_done", 32'(mon_if.done), 32'd1);
        check("to_pass", 32'(mon_if.pass), 32'd0);
        check("to_cyc",  mon_if.cycles, 32'd15);
        mon_if.finish = 4'b1111;
        step(); step();
        check("to_hold_tmo",  32'(mon_if.timeout), 32'd1);
        check("to_hold_pass", 32'(mon_if.pass), 32'd0);
        check("to_hold_cyc",  mon_if.cycles, 32'd15);
`else
        stuck_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (mon_if.done !== 1'b0) stuck_done = 1'b1;
        end
        check("nto_done", 32'(stuck_done), 32'd0);
        check("nto_tmo",  32'(mon_if.timeout), 32'd0);
        check("nto_cyc",  mon_if.cycles, 32'd100);
`endif
        mon_if.finish = '0;

        // Lane 3 finishes on the timeout cycle: completion wins
        do_reset();
        mon_if.finish = 4'b0111;
        for (int c = 0; c < 15; c++) step();
        mon_if.finish = 4'b1111;
        step();
        mon_if.finish = '0;
        check("edge_pass", 32'(mon_if.pass), 32'd1);
        check("edge_tmo",  32'(mon_if.timeout), 32'd0);
        check("edge_cyc",  mon_if.cycles, 32'd15);

        // Reset mid-run discards history, reset-cycle inputs are not recorded
        do_reset();
        mon_if.fail = 4'b0001;
        step();
        mon_if.fail = '0;
        step();
        check("mid_mask", 32'(mon_if.fail_mask), 32'h1);
        reset = 1'b1;
        mon_if.fail   = 4'b1111;
        mon_if.finish = 4'b1111;
        step();
        reset = 1'b0;
        mon_if.fail   = '0;
        mon_if.finish = '0;
        check("mid_rst_mask", 32'(mon_if.fail_mask), 32'd0);
        check("mid_rst_cyc",  mon_if.cycles, 32'd0);
        check("mid_rst_done", 32'(mon_if.done), 32'd0);
        check("mid_rst_idx",  32'(mon_if.first_fail_idx), 32'd0);
        step();
        mon_if.finish = 4'b1111;
        step();
        mon_if.finish = '0;
        check("clean_pass", 32'(mon_if.pass), 32'd1);
        check("clean_mask", 32'(mon_if.fail_mask), 32'd0);
        check("clean_cyc",  mon_if.cycles, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
